mult_share_sched: RTL

- Shares one pipelined array multiplier (WIDTH×WIDTH → 2·WIDTH, one issue per cycle, fixed latency, no stall input) among N requesters.
- Per cycle: round-robin selects one requester, drives the operands into the multiplier and tracks the operation's requester id through a tag pipeline.
- Captures each product into a response FIFO and returns it on a single shared, back-pressurable response channel.
- Credit control stops the non-stallable pipeline from overflowing the FIFO.

---
 rtl/mult_share_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mult_share_sched.sv
// Shares one fixed-latency pipelined multiplier among N requesters. Round-robin issue,
// tag pipeline for requester ids, credit-limited response FIFO on one shared channel.
module mult_share_sched #(
    parameter int WIDTH = 8,
    parameter int N     = 3,
    parameter int LAT   = 17,
    parameter int DEPTH = 8,
    parameter int IDW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*WIDTH-1:0]   req_x,
    input  logic [N*WIDTH-1:0]   req_y,
    output logic [WIDTH-1:0]     mul_x,
    output logic [WIDTH-1:0]     mul_y,
    output logic                 mul_start,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*WIDTH-1:0]   rsp_p,
    output logic                 busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]    DEPTH_C  = (CW + 1)'(DEPTH);
    localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // req_ready depends only on registered credit state and req_valid, never on rsp_ready.
    logic [IDW-1:0]   ptr;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    count;
    logic             can_issue;
    logic             issue;
    logic [N-1:0]     grant;
    logic [IDW-1:0]   gnt_id;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;

    logic [LAT-1:0]   tag_v;
    logic [IDW-1:0]   tag_id [LAT];
    logic             push;
    logic             pop;

    logic [IDW-1:0]     mem_id [DEPTH];
    logic [2*WIDTH-1:0] mem_p  [DEPTH];
    logic [AW-1:0]      wr_idx;
    logic [AW-1:0]      rd_idx;

    // Every issued op holds one credit until its response is popped.
    assign can_issue = ({1'b0, inflight} + {1'b0, count}) < DEPTH_C;

    always_comb begin
        grant  = '0;
        gnt_id = '0;
        sel_x  = '0;
        sel_y  = '0;
        issue  = 1'b0;
        if (can_issue && !reset) begin
            for (int i = 0; i < N; i++) begin
                if (!issue && req_valid[i] && (i >= int'(ptr))) begin
                    issue    = 1'b1;
                    grant[i] = 1'b1;
                    gnt_id   = IDW'(i);
                    sel_x    = req_x[i*WIDTH +: WIDTH];
                    sel_y    = req_y[i*WIDTH +: WIDTH];
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!issue && req_valid[i] && (i < int'(ptr))) begin
                    issue    = 1'b1;
                    grant[i] = 1'b1;
                    gnt_id   = IDW'(i);
                    sel_x    = req_x[i*WIDTH +: WIDTH];
                    sel_y    = req_y[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            mul_x     <= '0;
            mul_y     <= '0;
            mul_start <= 1'b0;
        end else begin
            mul_start <= issue;
            if (issue) begin
                mul_x <= sel_x;
                mul_y <= sel_y;
                ptr   <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    // Tag pipeline tracks which requester owns the product emerging LAT edges later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            for (int s = 0; s < LAT; s++) tag_id[s] <= '0;
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= gnt_id;
            for (int s = 1; s < LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    assign push = tag_v[LAT-1];
    assign pop  = rsp_valid & rsp_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else if (issue && !push) begin
            inflight <= inflight + 1'b1;
        end else if (!issue && push) begin
            inflight <= inflight - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_id[e] <= '0;
                mem_p[e]  <= '0;
            end
        end else begin
            if (push) begin
                mem_id[wr_idx] <= tag_id[LAT-1];
                mem_p[wr_idx]  <= mul_p;
                wr_idx         <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rsp_valid = (count != '0);
    assign rsp_id    = mem_id[rd_idx];
    assign rsp_p     = mem_p[rd_idx];
    assign busy      = (inflight != '0) | (count != '0);

endmodule
